note_lane_renderer: RTL

- Pixel-stage consumer of the 1280x720 timing generator: takes its hsync/vsync/active/x/y each clk and produces 12-bit RGB plus delayed syncs.
- Owns the falling-note state of the rhythm game: up to SLOTS notes per lane, advanced once per frame, spawned by the chart sequencer and cleared by player hits.
- Its outputs drive the video DAC/HDMI encoder directly.

---
 rtl/note_lane_renderer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/note_lane_renderer.sv
// Falling-note lane renderer: keeps per-lane note slots, advances them once per frame,
// resolves spawns and player hits, and paints the lanes on a 2-cycle pixel pipeline.
module note_lane_renderer #(
    parameter int          LANES       = 4,
    parameter int          SLOTS       = 4,
    parameter int          LANE_X0     = 384,
    parameter int          LANE_W      = 128,
    parameter int          NOTE_H      = 20,
    parameter int          NOTE_MARGIN = 4,
    parameter int          SPEED       = 4,
    parameter int          HIT_Y       = 620,
    parameter int          HIT_WIN     = 8,
    parameter logic [11:0] C_BG        = 12'h000,
    parameter logic [11:0] C_SEP       = 12'h444,
    parameter logic [11:0] C_HIT       = 12'hFFF,
    parameter logic [11:0] C_NOTE      = 12'hF80
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hsync_i,
    input  logic                     vsync_i,
    input  logic                     active_i,
    input  logic [10:0]              x_i,
    input  logic [9:0]               y_i,
    input  logic                     spawn_valid,
    input  logic [$clog2(LANES)-1:0] spawn_lane,
    output logic                     spawn_ready,
    input  logic                     hit_valid,
    input  logic [$clog2(LANES)-1:0] hit_lane,
    output logic                     hit_ok,
    output logic                     hit_bad,
    output logic [LANES-1:0]         miss,
    output logic [11:0]              rgb,
    output logic                     hsync_o,
    output logic                     vsync_o
);

    localparam int LB = $clog2(LANES);
    localparam int SB = $clog2(SLOTS);
    localparam int WB = $clog2(LANE_W);

    localparam logic [10:0]   REGION_LO  = 11'(LANE_X0);
    localparam logic [10:0]   REGION_HI  = 11'(LANE_X0 + LANES * LANE_W);
    localparam logic [10:0]   SCREEN_H   = 11'd720;
    localparam logic [10:0]   CAND_LO    = 11'(HIT_Y - HIT_WIN);
    localparam logic [10:0]   CAND_HI    = 11'(HIT_Y + HIT_WIN);
    localparam logic [10:0]   NOTE_SPAN  = 11'(NOTE_H);
    localparam logic [10:0]   BOTTOM_OFS = 11'(NOTE_H - 1);
    localparam logic [10:0]   STEP       = 11'(SPEED);
    localparam logic [9:0]    LINE_LO    = 10'(HIT_Y - 1);
    localparam logic [9:0]    LINE_HI    = 10'(HIT_Y + 1);
    localparam logic [WB-1:0] OFF_LO     = WB'(NOTE_MARGIN);
    localparam logic [WB-1:0] OFF_HI     = WB'(LANE_W - NOTE_MARGIN);

    logic                 vsPrev_q;
    logic                 tick;
    logic [SLOTS-1:0]     valid_q [LANES];
    logic [SLOTS-1:0]     valid_d [LANES];
    logic [9:0]           noteY_q [LANES][SLOTS];
    logic [9:0]           noteY_d [LANES][SLOTS];
    logic [LANES-1:0]     miss_q, miss_d;
    logic                 hitOk_q, hitBad_q;

    logic                 hitFound;
    logic [SB-1:0]        hitSlot;
    logic [9:0]           bestY;
    logic                 spawnFree;
    logic [SB-1:0]        spawnSlot;
    logic                 spawnAccept;
    logic [10:0]          yNext;

    logic                 hs1_q, vs1_q, act1_q;
    logic [10:0]          x1_q;
    logic [9:0]           y1_q;
    logic [11:0]          rgb_q;
    logic                 hs2_q, vs2_q;

    logic [10:0]          rel;
    logic                 inRegion;
    logic [LB-1:0]        pixLane;
    logic [WB-1:0]        offset;
    logic                 noteHere;
    logic                 onHitLine;
    logic                 onSeparator;
    logic [11:0]          colour_d;

    assign tick = vsPrev_q & ~vsync_i;

    function automatic logic inHitWindow(input logic [9:0] top);
        logic [10:0] bottom;
        bottom = {1'b0, top} + BOTTOM_OFS;
        return (bottom >= CAND_LO) && (bottom <= CAND_HI);
    endfunction

    // Hit picks the lowest note (largest y) in the window; spawn takes the lowest free slot.
    always_comb begin
        hitFound  = 1'b0;
        hitSlot   = '0;
        bestY     = '0;
        spawnFree = 1'b0;
        spawnSlot = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (valid_q[hit_lane][s] && inHitWindow(noteY_q[hit_lane][s]) &&
                (!hitFound || noteY_q[hit_lane][s] > bestY)) begin
                hitFound = 1'b1;
                hitSlot  = SB'(s);
                bestY    = noteY_q[hit_lane][s];
            end
        end
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (!valid_q[spawn_lane][s]) begin
                spawnFree = 1'b1;
                spawnSlot = SB'(s);
            end
        end
    end

    assign spawn_ready = ~tick & spawnFree;
    assign spawnAccept = spawn_valid & spawn_ready;

    always_comb begin
        valid_d = valid_q;
        noteY_d = noteY_q;
        miss_d  = '0;
        yNext   = '0;
        if (tick) begin
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (valid_q[l][s] &&
                        !(hit_valid && hitFound && LB'(l) == hit_lane && SB'(s) == hitSlot)) begin
                        yNext = {1'b0, noteY_q[l][s]} + STEP;
                        if (yNext >= SCREEN_H) begin
                            valid_d[l][s] = 1'b0;
                            miss_d[l]     = 1'b1;
                        end else begin
                            noteY_d[l][s] = yNext[9:0];
                        end
                    end
                end
            end
        end
        if (hit_valid && hitFound) begin
            valid_d[hit_lane][hitSlot] = 1'b0;
        end
        if (spawnAccept) begin
            valid_d[spawn_lane][spawnSlot] = 1'b1;
            noteY_d[spawn_lane][spawnSlot] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsPrev_q <= 1'b1;
            for (int l = 0; l < LANES; l++) begin
                valid_q[l] <= '0;
                for (int s = 0; s < SLOTS; s++) begin
                    noteY_q[l][s] <= '0;
                end
            end
            miss_q   <= '0;
            hitOk_q  <= 1'b0;
            hitBad_q <= 1'b0;
        end else begin
            vsPrev_q <= vsync_i;
            valid_q  <= valid_d;
            noteY_q  <= noteY_d;
            miss_q   <= miss_d;
            hitOk_q  <= hit_valid & hitFound;
            hitBad_q <= hit_valid & ~hitFound;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            act1_q <= 1'b0;
            x1_q   <= '0;
            y1_q   <= '0;
        end else begin
            hs1_q  <= hsync_i;
            vs1_q  <= vsync_i;
            act1_q <= active_i;
            x1_q   <= x_i;
            y1_q   <= y_i;
        end
    end

    assign rel         = x1_q - REGION_LO;
    assign inRegion    = (x1_q >= REGION_LO) && (x1_q < REGION_HI);
    assign pixLane     = LB'(rel >> WB);
    assign offset      = rel[WB-1:0];
    assign onHitLine   = inRegion && (y1_q >= LINE_LO) && (y1_q <= LINE_HI);
    assign onSeparator = (inRegion && offset == '0) || (x1_q == REGION_HI);

    // Note test reads live slot state, so a mid-frame spawn or hit shows from the next pixel.
    always_comb begin
        noteHere = 1'b0;
        if (inRegion && offset >= OFF_LO && offset < OFF_HI) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (valid_q[pixLane][s] &&
                    ({1'b0, y1_q} >= {1'b0, noteY_q[pixLane][s]}) &&
                    ({1'b0, y1_q} < ({1'b0, noteY_q[pixLane][s]} + NOTE_SPAN))) begin
                    noteHere = 1'b1;
                end
            end
        end
    end

    always_comb begin
        colour_d = C_BG;
        if (!act1_q) begin
            colour_d = '0;
        end else if (noteHere) begin
            colour_d = C_NOTE;
        end else if (onHitLine) begin
            colour_d = C_HIT;
        end else if (onSeparator) begin
            colour_d = C_SEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
        end else begin
            rgb_q <= colour_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign rgb     = rgb_q;
    assign hsync_o = hs2_q;
    assign vsync_o = vs2_q;
    assign hit_ok  = hitOk_q;
    assign hit_bad = hitBad_q;
    assign miss    = miss_q;

endmodule
